// File: rtl/window_pkg.sv
// Shared windowing constants and fixed-point helpers, also used by the FFT input stage.
// Pure definitions, no latency; no flow control.
// Helpers are written over 64-bit signed values so any instantiated width fits.
package window_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_COEF_W = 8;
    localparam int DEF_FRAC_W = 7;

    // Unity gain in a coefficient with frac_w fractional bits.
    function automatic int one_q(input int frac_w);
        return 1 << frac_w;
    endfunction

    // Round half up, drop frac_w bits, clamp to a data_w-bit signed range.
    function automatic longint round_sat(input longint prod, input int frac_w, input int data_w);
        longint r;
        longint hi;
        longint lo;
        r  = (prod + (longint'(1) << (frac_w - 1))) >>> frac_w;
        hi = (longint'(1) << (data_w - 1)) - 1;
        lo = -hi - 1;
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

endpackage

// File: rtl/window_mac.sv
// Signed sample times unsigned coefficient, rounded and saturated back to DATA_W.
// Combinational, zero latency; no flow control.
// The coefficient is zero-extended so values above 1.0 stay positive.
module window_mac
    import window_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic signed [DATA_W-1:0] sample,
    input  logic        [COEF_W-1:0] coef,
    output logic signed [DATA_W-1:0] y
);

    localparam int P = DATA_W + COEF_W + 1;

    logic signed [P-1:0] sample_ext;
    logic signed [P-1:0] coef_ext;
    logic signed [P-1:0] prod;

    assign sample_ext = P'(sample);
    assign coef_ext   = P'($signed({1'b0, coef}));
    assign prod       = sample_ext * coef_ext;
    assign y          = DATA_W'(round_sat(longint'(prod), FRAC_W, DATA_W));

endmodule

// File: rtl/window_stream.sv
// Streaming window stage: per-position coefficient multiply, round, saturate, frame index tagging.
// Latency 2 cycles (S1 sample/coef register, S2 output register), 1 sample/cycle.
// Both stages advance only when the output is empty or taken; s_ready mirrors that enable.
module window_stream
    import window_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int IDX_W  = $clog2(SIZE)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     sync_clr,
    input  logic                     bypass,
    input  logic                     coef_we,
    input  logic        [IDX_W-1:0]  coef_addr,
    input  logic        [COEF_W-1:0] coef_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic signed [DATA_W-1:0] m_data,
    output logic        [IDX_W-1:0]  m_index,
    output logic                     m_last
);

    localparam logic [COEF_W-1:0] ONE      = COEF_W'(one_q(FRAC_W));
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(SIZE - 1);
    localparam logic [IDX_W:0]    SIZE_X   = (IDX_W + 1)'(SIZE);

    logic        [COEF_W-1:0] coef_tab [SIZE];
    logic        [IDX_W-1:0]  idx;
    logic        [IDX_W-1:0]  cur_idx;
    logic                     en;
    logic                     acc;

    logic                     s1_vld;
    logic signed [DATA_W-1:0] s1_data;
    logic        [COEF_W-1:0] s1_coef;
    logic        [IDX_W-1:0]  s1_idx;
    logic signed [DATA_W-1:0] mac_y;

    assign en      = !m_valid || m_ready;
    assign s_ready = en && !rst;
    assign acc     = s_valid && s_ready;
    assign cur_idx = sync_clr ? '0 : idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (acc) begin
            idx <= (cur_idx == LAST_IDX) ? '0 : cur_idx + IDX_W'(1);
        end else if (sync_clr) begin
            idx <= '0;
        end
    end

    // Reads happen at acceptance from the registered table, so a same-cycle write is seen next time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++)
                coef_tab[i] <= ONE;
        end else if (coef_we && ({1'b0, coef_addr} < SIZE_X)) begin
            coef_tab[coef_addr] <= coef_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_data <= '0;
            s1_coef <= '0;
            s1_idx  <= '0;
        end else if (en) begin
            s1_vld <= acc;
            if (acc) begin
                s1_data <= s_data;
                s1_coef <= bypass ? ONE : coef_tab[cur_idx];
                s1_idx  <= cur_idx;
            end
        end
    end

    window_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC_W (FRAC_W)
    ) u_mac (
        .sample (s1_data),
        .coef   (s1_coef),
        .y      (mac_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_index <= '0;
            m_last  <= 1'b0;
        end else if (en) begin
            m_valid <= s1_vld;
            if (s1_vld) begin
                m_data  <= mac_y;
                m_index <= s1_idx;
                m_last  <= (s1_idx == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_window_stream.sv
// Directed + randomized bench for window_stream against a real-arithmetic reference queue.
module tb_window_stream;

    localparam int SIZE   = 8;
    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int FRAC_W = 7;
    localparam int IDX_W  = 3;
    localparam int ONE    = 128;

    logic                     clk;
    logic                     rst;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic                     sync_clr;
    logic                     bypass;
    logic                     coef_we;
    logic        [IDX_W-1:0]  coef_addr;
    logic        [COEF_W-1:0] coef_data;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data;
    logic        [IDX_W-1:0]  m_index;
    logic                     m_last;

    window_stream #(
        .SIZE   (SIZE),
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .FRAC_W (FRAC_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .sync_clr  (sync_clr),
        .bypass    (bypass),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_index   (m_index),
        .m_last    (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int d;
        int i;
        int l;
    } exp_t;

    exp_t expq[$];
    int   mtab[SIZE];
    int   midx;
    int   total;
    int   bad;
    int   cyc;
    int   last_acc;
    int   lat_arm;
    int   lat_acc;
    int   prev_stall;
    int   prev_d;
    int   prev_i;
    int   prev_l;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected output: value * coef / 2^FRAC_W, nearest with ties upward, clipped to the sample range.
    function automatic int win(input int d, input int c);
        real r;
        int  v;
        r = real'(d * c) / real'(ONE);
        v = int'($floor(r + 0.5));
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < SIZE; i++) mtab[i] = ONE;
        midx = 0;
        expq.delete();
        prev_stall = 0;
    endtask

    // One clock: observe at the falling edge, update the model, then step past the rising edge.
    task automatic tick();
        exp_t e;
        int   i;
        int   c;
        @(negedge clk);
        cyc++;
        last_acc = 0;
        if (prev_stall != 0) begin
            chk("stall_valid", int'(m_valid), 1);
            chk("stall_data", int'(m_data), prev_d);
            chk("stall_index", int'(m_index), prev_i);
            chk("stall_last", int'(m_last), prev_l);
        end
        if (lat_arm != 0 && lat_acc >= 0 && m_valid) begin
            chk("first_latency", cyc - lat_acc, 2);
            lat_arm = 0;
        end
        if (m_valid && m_ready) begin
            if (expq.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("out_data", int'(m_data), e.d);
                chk("out_index", int'(m_index), e.i);
                chk("out_last", int'(m_last), e.l);
            end
        end
        prev_stall = (m_valid && !m_ready) ? 1 : 0;
        prev_d = int'(m_data);
        prev_i = int'(m_index);
        prev_l = int'(m_last);
        if (s_valid && s_ready) begin
            last_acc = 1;
            if (lat_arm != 0 && lat_acc < 0) lat_acc = cyc;
            i = sync_clr ? 0 : midx;
            c = bypass ? ONE : mtab[i];
            e.d = win(int'(s_data), c);
            e.i = i;
            e.l = (i == SIZE - 1) ? 1 : 0;
            expq.push_back(e);
            midx = (i + 1) % SIZE;
        end else if (sync_clr) begin
            midx = 0;
        end
        if (coef_we && int'(coef_addr) < SIZE) mtab[int'(coef_addr)] = int'(coef_data);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic sc, input logic bp);
        int n;
        s_valid  = 1'b1;
        s_data   = DATA_W'(d);
        sync_clr = sc;
        bypass   = bp;
        n = 0;
        do begin
            tick();
            n++;
        end while (last_acc == 0 && n < 50);
        if (last_acc == 0) chk("send_timeout", 0, 1);
        s_valid  = 1'b0;
        sync_clr = 1'b0;
        bypass   = 1'b0;
        coef_we  = 1'b0;
    endtask

    task automatic write_coef(input int a, input int v);
        coef_we   = 1'b1;
        coef_addr = IDX_W'(a);
        coef_data = COEF_W'(v);
        tick();
        coef_we = 1'b0;
    endtask

    task automatic drain();
        int n;
        s_valid  = 1'b0;
        sync_clr = 1'b0;
        coef_we  = 1'b0;
        m_ready  = 1'b1;
        n = 0;
        while (expq.size() > 0 && n < 40) begin
            tick();
            n++;
        end
        chk("drain_empty", expq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int n;
        int coefs[SIZE] = '{0, 16, 64, 118, 128, 118, 64, 16};
        total = 0; bad = 0; cyc = 0; lat_arm = 0; lat_acc = -1;
        rst = 1'b1; s_valid = 1'b0; s_data = '0; sync_clr = 1'b0; bypass = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0; m_ready = 1'b0;
        model_reset();

        // Reset state
        #12;
        chk("rst_s_ready", int'(s_ready), 0);
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_m_index", int'(m_index), 0);
        chk("rst_m_last", int'(m_last), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("s_ready_after_rst", int'(s_ready), 1);

        // Default 1.0 table, latency of the first sample
        lat_arm = 1;
        lat_acc = -1;
        for (int k = 0; k < SIZE; k++) send(50, 1'b0, 1'b0);
        drain();
        chk("latency_seen", lat_arm, 0);

        // Hamming-like table against a constant stream
        for (int a = 0; a < SIZE; a++) write_coef(a, coefs[a]);
        for (int k = 0; k < SIZE; k++) send(100, 1'b0, 1'b0);
        drain();

        // Saturation and rounding of -0.5
        write_coef(0, 255);
        write_coef(1, 255);
        write_coef(2, 64);
        send(127, 1'b1, 1'b0);
        send(-128, 1'b0, 1'b0);
        send(-1, 1'b0, 1'b0);
        // Same-cycle write and read of index 3 must use the old coefficient
        coef_we = 1'b1; coef_addr = 3'd3; coef_data = 8'd0;
        send(100, 1'b0, 1'b0);
        for (int k = 0; k < SIZE; k++) send(100, 1'b0, 1'b0);
        drain();

        // Random backpressure, bypass, sync_clr and table writes
        for (int a = 0; a < SIZE; a++) write_coef(a, int'($urandom_range(0, 255)));
        n_acc = 0;
        n = 0;
        while (n_acc < 64 && n < 2000) begin
            s_valid   = ($urandom_range(0, 3) != 0);
            s_data    = DATA_W'($urandom);
            bypass    = ($urandom_range(0, 7) == 0);
            sync_clr  = ($urandom_range(0, 15) == 0);
            m_ready   = ($urandom_range(0, 1) == 1);
            coef_we   = ($urandom_range(0, 7) == 0);
            coef_addr = IDX_W'($urandom);
            coef_data = COEF_W'($urandom);
            tick();
            n_acc += last_acc;
            n++;
        end
        chk("bp_accepted", n_acc, 64);
        bypass = 1'b0;
        drain();

        // sync_clr on the 4th sample of a frame, then sync_clr with no sample
        send(20, 1'b1, 1'b0);
        send(21, 1'b0, 1'b0);
        send(22, 1'b0, 1'b0);
        send(23, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) send(30 + k, 1'b0, 1'b0);
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        send(40, 1'b0, 1'b0);
        // Bypass mid-stream
        send(127, 1'b0, 1'b1);
        send(-128, 1'b0, 1'b1);
        send(-77, 1'b0, 1'b1);
        send(90, 1'b0, 1'b0);
        send(5, 1'b0, 1'b1);
        drain();

        // Reset mid-frame while the output is stalled
        m_ready = 1'b0;
        send(30, 1'b0, 1'b0);
        send(40, 1'b0, 1'b0);
        tick();
        chk("pre_rst_valid", int'(m_valid), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", int'(m_valid), 0);
        chk("mid_rst_s_ready", int'(s_ready), 0);
        chk("mid_rst_m_index", int'(m_index), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        for (int k = 0; k < SIZE; k++) send(77 - 20 * k, 1'b0, 1'b0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/window_stream.md
Name: window_stream

Overview:
Streaming fixed-point window stage, the parametrised successor to the combinational frame-wide windowing block. Accepts one signed sample per handshake, multiplies it by the coefficient for its position in the current frame, then rounds, saturates and emits it on a valid/ready output. Sits between the sample source and the FFT core. Holds a run-time-loadable coefficient table (Hamming by default from software), a frame position counter and a bypass mode.

Parameters:
SIZE, 8, frame length in samples (>=2); coefficient table depth
DATA_W, 8, signed sample width in and out
COEF_W, 8, unsigned coefficient width
FRAC_W, 7, fractional bits of coefficient (1.0 = 2^FRAC_W); FRAC_W < COEF_W
IDX_W, $clog2(SIZE), frame index width (derived)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
s_valid  in  1  input sample valid
s_ready  out  1  block can accept sample
s_data  in  DATA_W  signed input sample
sync_clr  in  1  force next accepted sample to index 0
bypass  in  1  treat coefficient as 1.0 (sampled with each accepted sample)
coef_we  in  1  coefficient table write strobe
coef_addr  in  IDX_W  table write address
coef_data  in  COEF_W  table write data
m_valid  out  1  output sample valid
m_ready  in  1  downstream accepts
m_data  out  DATA_W  windowed signed sample
m_index  out  IDX_W  frame position of m_data
m_last  out  1  m_index == SIZE-1

Behaviour:
- Reset (async): s_ready=0 while rst high, 1 on first cycle after release; m_valid=0, m_data=0, m_index=0, m_last=0; index counter=0; all table entries = 2^FRAC_W (1.0).
- Pipeline: 2 stages (S1 multiply, S2 round/saturate/output register). Advance enable en = !m_valid || m_ready; both stages move together; s_ready = en.
- Accept when s_valid && s_ready. Latency: accepted at edge N -> m_valid high after edge N+2 if no stall. Full throughput 1 sample/cycle.
- Stall: m_valid && !m_ready holds m_data/m_index/m_last and S1 contents stable; no sample lost or duplicated.
- Index counter: increments per accepted sample, wraps SIZE-1 -> 0. sync_clr with an accepted sample: that sample gets index 0, counter -> 1. sync_clr without acceptance: counter -> 0. SIZE non-power-of-2 must wrap correctly.
- Coefficient fetch: coefficient read at acceptance using that sample's index. Write to table takes effect for samples accepted on later cycles; same-cycle write and read of same address returns old value. coef_addr >= SIZE: write ignored.
- Arithmetic: product = s_data (signed) * {0,coef} (unsigned) at DATA_W+COEF_W+1 bits; add 2^(FRAC_W-1) (round half up); arithmetic shift right FRAC_W; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- bypass=1: coefficient forced to 2^FRAC_W; m_data == s_data exactly; latency and index counting unchanged.
- Reset mid-frame: in-flight samples discarded, index restarts at 0, table returns to 1.0.

Decomposition:
- Shared package window_pkg: ONE_Q constant (2^FRAC_W) function, saturate/round helper function, default DATA_W/COEF_W/FRAC_W constants shared with FFT input stage.
- One sub-module: window_mac (combinational multiply + round + saturate, parametrised DATA_W/COEF_W/FRAC_W), instantiated between S1 and S2 registers.

Test Plan:
- Reset defaults: after rst, stream 8 samples of 50 -> m_data all 50, m_index 0..7, m_last only on 7, first m_valid 2 cycles after first accept.
- Load table {0,16,64,118,128,118,64,16}, stream constant 100 -> outputs {0,13,50,92,100,92,50,13} (rounded).
- Saturation: coef 255 (~1.99), s_data 127 -> 127; s_data -128 -> -128; s_data -1, coef 64 -> 0 (round half up of -0.5).
- Backpressure: random m_ready 50% over 64 samples -> output sequence equals reference model, no drops/duplicates, stable outputs while stalled.
- sync_clr asserted on 4th sample of a frame -> that sample m_index 0, following samples 1,2,...; bypass=1 mid-stream -> affected samples pass unchanged.
- Async rst asserted mid-frame with m_valid high -> m_valid drops immediately, next frame starts at index 0 with 1.0 coefficients.
